vga_timing_ctrl: RTL and testbench

Display timing controller that sequences the 640x480@60 VGA pixel datapath. It generates hsync/vsync and requests one pixel per clock from an upstream pixel source, such as a colour-bar or image generator, exactly one cycle ahead of the active region. It then gates the returned RGB565 data onto vga_rgb. It runs and stops only on frame boundaries under an enable, so the monitor never sees a truncated frame.

---
 rtl/vga_timing_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_ctrl
// Purpose  : 640x480@60 VGA display timing controller. It generates
//            hsync/vsync and requests one pixel per clock from an upstream
//            pixel source, one cycle ahead of the active region. The
//            returned RGB565 data is gated onto vga_rgb. The controller
//            starts on a frame boundary and stops only on a frame boundary,
//            so the monitor never sees a truncated frame.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   sys_clk      in   1   pixel clock (25 MHz nominal)
//   sys_rst      in   1   synchronous, active-high reset
//   en           in   1   run request, sampled every cycle
//   pix_data     in  16   RGB565 from the pixel source, valid the cycle
//                         after pix_data_req
//   pix_data_req out  1   request for the pixel at (pix_x, pix_y)
//   pix_x        out 10   requested column, 10'h3FF when no request
//   pix_y        out 10   requested row, 10'h3FF when no request
//   hsync        out  1   active-high horizontal sync
//   vsync        out  1   active-high vertical sync
//   vga_rgb      out 16   RGB565 to the DAC, 0 outside the active region
//   frame_start  out  1   one-cycle pulse at cnt_h=0, cnt_v=0
//   busy         out  1   high while running or while a stop is pending
// ============================================================================
module vga_timing_ctrl #(
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int H_VALID = 640,
    parameter int H_FRONT = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_VALID = 480,
    parameter int V_FRONT = 10
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        en,
    input  logic [15:0] pix_data,
    output logic        pix_data_req,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic [15:0] vga_rgb,
    output logic        frame_start,
    output logic        busy
);

    // ------------------------------------------------------------------
    // Derived timing constants
    // ------------------------------------------------------------------
    localparam int C_H_TOTAL_I = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int C_V_TOTAL_I = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam int C_H_ACT_I   = H_SYNC + H_BACK;
    localparam int C_V_ACT_I   = V_SYNC + V_BACK;

    // Counter-width versions of the thresholds used by the decode logic.
    localparam logic [9:0] C_H_LAST    = 10'(C_H_TOTAL_I - 1);
    localparam logic [9:0] C_V_LAST    = 10'(C_V_TOTAL_I - 1);
    localparam logic [9:0] C_H_SYNC    = 10'(H_SYNC);
    localparam logic [9:0] C_V_SYNC    = 10'(V_SYNC);
    localparam logic [9:0] C_H_ACT     = 10'(C_H_ACT_I);
    localparam logic [9:0] C_H_ACT_END = 10'(C_H_ACT_I + H_VALID);
    localparam logic [9:0] C_V_ACT     = 10'(C_V_ACT_I);
    localparam logic [9:0] C_V_ACT_END = 10'(C_V_ACT_I + V_VALID);
    // Requests lead the active window by exactly one pixel clock.
    localparam logic [9:0] C_H_REQ     = 10'(C_H_ACT_I - 1);
    localparam logic [9:0] C_H_REQ_END = 10'(C_H_ACT_I + H_VALID - 1);

    localparam logic [9:0]  C_COORD_IDLE = 10'h3FF;
    localparam logic [15:0] C_RGB_BLANK  = 16'h0000;

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity: all sums must fit the 10-bit
    // counters, and the request lead needs at least one cycle of
    // sync+back porch in front of the active window.
    // ------------------------------------------------------------------
    if (C_H_TOTAL_I > 1023 || C_V_TOTAL_I > 1023) begin : g_width_check
        $error("vga_timing_ctrl: H/V totals must fit in 10 bits");
    end

    if (C_H_ACT_I < 1 || H_VALID < 1 || V_VALID < 1) begin : g_shape_check
        $error("vga_timing_ctrl: need H_SYNC+H_BACK >= 1 and non-empty active area");
    end

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_STOP_PEND = 2'd2
    } state_t;

    state_t      r_state_q;
    state_t      w_state_d;
    logic [9:0]  r_cnt_h_q;
    logic [9:0]  r_cnt_v_q;
    logic [9:0]  w_cnt_h_d;
    logic [9:0]  w_cnt_v_d;

    logic        w_last_h;
    logic        w_last_v;
    logic        w_frame_end;

    logic        w_busy;
    logic        w_h_active;
    logic        w_v_active;
    logic        w_h_req;
    logic        w_req;
    logic        w_rgb_valid;

    // ------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        w_last_h    = (r_cnt_h_q == C_H_LAST);
        w_last_v    = (r_cnt_v_q == C_V_LAST);
        w_frame_end = w_last_h && w_last_v;

        w_state_d = r_state_q;
        case (r_state_q)
            ST_IDLE: begin
                if (en) begin
                    w_state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A stop request on the very last frame cycle can go
                // straight to IDLE; otherwise finish the current frame.
                if (!en) begin
                    w_state_d = w_frame_end ? ST_IDLE : ST_STOP_PEND;
                end
            end
            ST_STOP_PEND: begin
                // Re-asserting en cancels the stop, including on the last
                // cycle of the frame, so the next frame follows seamlessly.
                if (en) begin
                    w_state_d = ST_RUN;
                end else if (w_frame_end) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        // Counters are held at zero in IDLE so the first RUN cycle is
        // always (0,0). Transitions into IDLE occur only on the last frame
        // cycle, where the wrap already yields zero.
        if (r_state_q == ST_IDLE) begin
            w_cnt_h_d = 10'd0;
            w_cnt_v_d = 10'd0;
        end else begin
            w_cnt_h_d = w_last_h ? 10'd0 : r_cnt_h_q + 10'd1;
            w_cnt_v_d = r_cnt_v_q;
            if (w_last_h) begin
                w_cnt_v_d = w_last_v ? 10'd0 : r_cnt_v_q + 10'd1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state_q <= ST_IDLE;
            r_cnt_h_q <= 10'd0;
            r_cnt_v_q <= 10'd0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_h_q <= w_cnt_h_d;
            r_cnt_v_q <= w_cnt_v_d;
        end
    end

    // ------------------------------------------------------------------
    // Output decode from the registered counters. Every output is forced
    // to its idle value when not busy, because the zeroed counters would
    // otherwise decode as sync-active.
    // ------------------------------------------------------------------
    always_comb begin
        w_busy      = (r_state_q != ST_IDLE);
        w_h_active  = (r_cnt_h_q >= C_H_ACT) && (r_cnt_h_q < C_H_ACT_END);
        w_v_active  = (r_cnt_v_q >= C_V_ACT) && (r_cnt_v_q < C_V_ACT_END);
        w_h_req     = (r_cnt_h_q >= C_H_REQ) && (r_cnt_h_q < C_H_REQ_END);
        w_req       = w_busy && w_h_req && w_v_active;
        w_rgb_valid = w_busy && w_h_active && w_v_active;

        busy         = w_busy;
        hsync        = w_busy && (r_cnt_h_q < C_H_SYNC);
        vsync        = w_busy && (r_cnt_v_q < C_V_SYNC);
        frame_start  = w_busy && (r_cnt_h_q == 10'd0) && (r_cnt_v_q == 10'd0);
        pix_data_req = w_req;
        pix_x        = w_req ? (r_cnt_h_q - C_H_REQ) : C_COORD_IDLE;
        pix_y        = w_req ? (r_cnt_v_q - C_V_ACT) : C_COORD_IDLE;
        // The source answers one cycle after the request, which is exactly
        // when the same pixel becomes active, so no realignment register.
        vga_rgb      = w_rgb_valid ? pix_data : C_RGB_BLANK;
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_ctrl
// Purpose  : Self-checking bench for vga_timing_ctrl. One instance uses the
//            640x480 timing for line-level checks; a second instance with a
//            tiny raster exercises whole frames, stop/restart and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_ctrl;

    // Full-size raster (instance A)
    localparam int AHS = 96, AHA = 144, AHV = 640, AHT = 800;
    localparam int AVS = 2,  AVA = 35,  AVV = 480, AVT = 525;
    // Tiny raster (instance B): 17 x 12 = 204 cycles per frame
    localparam int BHS = 4, BHB = 3, BHV = 8, BHF = 2;
    localparam int BVS = 2, BVB = 3, BVV = 5, BVF = 2;
    localparam int BHA = BHS + BHB, BHT = BHS + BHB + BHV + BHF;
    localparam int BVA = BVS + BVB, BVT = BVS + BVB + BVV + BVF;
    localparam int BFR = BHT * BVT;

    // {req, pix_x, pix_y, hsync, vsync, vga_rgb, frame_start, busy}
    localparam logic [40:0] IDLE_VEC = {1'b0, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic        rst_a, en_a, req_a, hs_a, vs_a, fs_a, busy_a;
    logic [15:0] pd_a, rgb_a;
    logic [9:0]  px_a, py_a;
    logic        rst_b, en_b, req_b, hs_b, vs_b, fs_b, busy_b;
    logic [15:0] pd_b, rgb_b;
    logic [9:0]  px_b, py_b;
    logic [40:0] obs_a, obs_b;

    assign obs_a = {req_a, px_a, py_a, hs_a, vs_a, rgb_a, fs_a, busy_a};
    assign obs_b = {req_b, px_b, py_b, hs_b, vs_b, rgb_b, fs_b, busy_b};

    int checks = 0;
    int errors = 0;
    int k_a = 0;
    int k_b = 0;

    vga_timing_ctrl dut_a (
        .sys_clk(clk), .sys_rst(rst_a), .en(en_a), .pix_data(pd_a),
        .pix_data_req(req_a), .pix_x(px_a), .pix_y(py_a),
        .hsync(hs_a), .vsync(vs_a), .vga_rgb(rgb_a),
        .frame_start(fs_a), .busy(busy_a)
    );

    vga_timing_ctrl #(
        .H_SYNC(BHS), .H_BACK(BHB), .H_VALID(BHV), .H_FRONT(BHF),
        .V_SYNC(BVS), .V_BACK(BVB), .V_VALID(BVV), .V_FRONT(BVF)
    ) dut_b (
        .sys_clk(clk), .sys_rst(rst_b), .en(en_b), .pix_data(pd_b),
        .pix_data_req(req_b), .pix_x(px_b), .pix_y(py_b),
        .hsync(hs_b), .vsync(vs_b), .vga_rgb(rgb_b),
        .frame_start(fs_b), .busy(busy_b)
    );

    // Upstream pixel sources: registered answer {y[5:0], x} to a request,
    // a junk value otherwise so that blanking of vga_rgb is visible.
    always @(posedge clk) begin
        pd_a <= req_a ? {py_a[5:0], px_a} : 16'hDEAD;
        pd_b <= req_b ? {py_b[5:0], px_b} : 16'hDEAD;
    end

    // Reference model of the output vector at raster position (h, v).
    function automatic logic [40:0] exp_vec(int h, int v, int hs_w, int hact, int hval,
                                            int vs_w, int vact, int vval);
        logic        req, valid;
        logic [9:0]  px, py, vx, vy;
        logic [15:0] rgb;
        req   = (v >= vact) && (v < vact + vval) && (h >= hact - 1) && (h < hact + hval - 1);
        valid = (v >= vact) && (v < vact + vval) && (h >= hact) && (h < hact + hval);
        px    = req ? 10'(h - (hact - 1)) : 10'h3FF;
        py    = req ? 10'(v - vact) : 10'h3FF;
        vx    = 10'(h - hact);
        vy    = 10'(v - vact);
        rgb   = valid ? {vy[5:0], vx} : 16'h0000;
        return {req, px, py, (h < hs_w) ? 1'b1 : 1'b0, (v < vs_w) ? 1'b1 : 1'b0,
                rgb, (h == 0 && v == 0) ? 1'b1 : 1'b0, 1'b1};
    endfunction

    function automatic logic [40:0] exp_a(int k);
        return exp_vec(k % AHT, (k / AHT) % AVT, AHS, AHA, AHV, AVS, AVA, AVV);
    endfunction

    function automatic logic [40:0] exp_b(int k);
        return exp_vec(k % BHT, (k / BHT) % BVT, BHS, BHA, BHV, BVS, BVA, BVV);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_a = 1'b1; en_a = 1'b0;
        rst_b = 1'b1; en_b = 1'b0;
        repeat (3) tick();
        checks++;
        if (obs_a !== IDLE_VEC) begin
            errors++; $display("FAIL reset_a: got %h expected %h", obs_a, IDLE_VEC);
        end
        checks++;
        if (obs_b !== IDLE_VEC) begin
            errors++; $display("FAIL reset_b: got %h expected %h", obs_b, IDLE_VEC);
        end
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (4) tick();
        checks++;
        if (obs_a !== IDLE_VEC) begin
            errors++; $display("FAIL idle_a: got %h expected %h", obs_a, IDLE_VEC);
        end
        checks++;
        if (obs_b !== IDLE_VEC) begin
            errors++; $display("FAIL idle_b: got %h expected %h", obs_b, IDLE_VEC);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_horizontal();
        int hs_hi = 0;
        int fs_cnt = 0;
        en_a = 1'b1;
        tick();
        k_a = 0;
        checks++;
        if (fs_a !== 1'b1) begin
            errors++; $display("FAIL first_frame_start: got %b expected 1", fs_a);
        end
        checks++;
        if (busy_a !== 1'b1) begin
            errors++; $display("FAIL run_busy: got %b expected 1", busy_a);
        end
        for (int i = 0; i < AHT; i++) begin
            if (hs_a === 1'b1) hs_hi++;
            if (fs_a === 1'b1) fs_cnt++;
            if (i == AHS - 1 && hs_a !== 1'b1) hs_hi = -1000;
            if (i == AHS && hs_a !== 1'b0) hs_hi = -1000;
            tick(); k_a++;
        end
        checks++;
        if (hs_hi !== AHS) begin
            errors++; $display("FAIL hsync_width: got %0d expected %0d", hs_hi, AHS);
        end
        checks++;
        if (hs_a !== 1'b1) begin
            errors++; $display("FAIL hsync_period: got %b expected 1 at cycle 800", hs_a);
        end
        checks++;
        if (fs_cnt !== 1) begin
            errors++; $display("FAIL frame_start_once: got %0d expected 1", fs_cnt);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_request_align();
        int          nbad = 0;
        int          first_k = -1;
        int          early_req = 0;
        logic [40:0] e, got_first, exp_first;
        logic        req143 = 1'b0, req799 = 1'b1;
        logic [9:0]  px143 = '1, py143 = '1, px782 = '0;
        logic [15:0] rgb144 = '1, rgb145 = '0, rgb783 = '0, rgb784 = '1;
        got_first = '0; exp_first = '0;
        while (k_a < (AVA + 1) * AHT) begin
            e = exp_a(k_a);
            if (obs_a !== e) begin
                nbad++;
                if (first_k < 0) begin first_k = k_a; got_first = obs_a; exp_first = e; end
            end
            if (k_a < AVA * AHT && req_a !== 1'b0) early_req++;
            if (k_a / AHT == AVA) begin
                case (k_a % AHT)
                    143: begin req143 = req_a; px143 = px_a; py143 = py_a; end
                    144: rgb144 = rgb_a;
                    145: rgb145 = rgb_a;
                    782: px782 = px_a;
                    783: rgb783 = rgb_a;
                    784: rgb784 = rgb_a;
                    799: req799 = req_a;
                    default: ;
                endcase
            end
            tick(); k_a++;
        end
        checks++;
        if (nbad !== 0) begin
            errors++;
            $display("FAIL line_model_a: %0d bad cycles, first k=%0d got %h expected %h",
                     nbad, first_k, got_first, exp_first);
        end
        checks++;
        if (early_req !== 0) begin
            errors++; $display("FAIL no_req_lines_0_34: got %0d requests expected 0", early_req);
        end
        checks++;
        if ({req143, px143, py143} !== {1'b1, 10'd0, 10'd0}) begin
            errors++; $display("FAIL first_request: got req=%b x=%0d y=%0d expected 1,0,0", req143, px143, py143);
        end
        checks++;
        if (rgb144 !== 16'h0000 || rgb145 !== 16'h0001) begin
            errors++; $display("FAIL first_pixels: got %h,%h expected 0000,0001", rgb144, rgb145);
        end
        checks++;
        if (px782 !== 10'd639) begin
            errors++; $display("FAIL last_request_x: got %0d expected 639", px782);
        end
        checks++;
        if (rgb783 !== 16'h027F || rgb784 !== 16'h0000) begin
            errors++; $display("FAIL last_pixel: got %h,%h expected 027f,0000", rgb783, rgb784);
        end
        checks++;
        if (req799 !== 1'b0) begin
            errors++; $display("FAIL no_req_at_799: got %b expected 0", req799);
        end
        rst_a = 1'b1; en_a = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_vertical();
        int          nbad = 0, first_k = -1;
        int          vs_hi = 0, fs_cnt = 0, req_cnt = 0, req_blank = 0;
        logic [40:0] e;
        en_b = 1'b1;
        tick();
        k_b = 0;
        while (k_b < 2 * BFR) begin
            e = exp_b(k_b);
            if (obs_b !== e) begin
                nbad++;
                if (first_k < 0) begin
                    first_k = k_b;
                    $display("first vertical difference at k=%0d: got %h expected %h", k_b, obs_b, e);
                end
            end
            if (vs_b === 1'b1) vs_hi++;
            if (fs_b === 1'b1) fs_cnt++;
            if (req_b === 1'b1) req_cnt++;
            if (req_b === 1'b1 && ((k_b / BHT) % BVT < BVA || (k_b / BHT) % BVT >= BVA + BVV)) req_blank++;
            tick(); k_b++;
        end
        checks++;
        if (nbad !== 0) begin
            errors++; $display("FAIL frame_model_b: got %0d bad cycles expected 0 (first k=%0d)", nbad, first_k);
        end
        checks++;
        if (vs_hi !== 2 * BVS * BHT) begin
            errors++; $display("FAIL vsync_width: got %0d expected %0d", vs_hi, 2 * BVS * BHT);
        end
        checks++;
        if (fs_cnt !== 2 || fs_b !== 1'b1) begin
            errors++; $display("FAIL frame_start_period: got count=%0d now=%b expected 2,1", fs_cnt, fs_b);
        end
        checks++;
        if (req_cnt !== 2 * BHV * BVV || req_blank !== 0) begin
            errors++; $display("FAIL request_count: got %0d/%0d blank expected %0d/0",
                               req_cnt, req_blank, 2 * BHV * BVV);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_stop();
        int          nbad = 0;
        logic [40:0] e;
        while (k_b < 3 * BFR) begin
            e = exp_b(k_b);
            if (obs_b !== e) nbad++;
            if (k_b == 2 * BFR + 3 * BHT) en_b = 1'b0;
            tick(); k_b++;
        end
        checks++;
        if (nbad !== 0) begin
            errors++; $display("FAIL stop_pend_outputs: got %0d bad cycles expected 0", nbad);
        end
        checks++;
        if (obs_b !== IDLE_VEC) begin
            errors++; $display("FAIL stop_at_frame_end: got %h expected %h", obs_b, IDLE_VEC);
        end
        repeat (5) tick();
        checks++;
        if (obs_b !== IDLE_VEC) begin
            errors++; $display("FAIL stays_idle: got %h expected %h", obs_b, IDLE_VEC);
        end
    endtask

    // ------------------------------------------------------------------
    // Stop requested then cancelled mid-frame: timing must be unbroken,
    // followed by a stop requested on the very last frame cycle.
    task automatic test_back_to_back();
        int          nbad = 0, first_k = -1;
        logic [40:0] e;
        en_b = 1'b1;
        tick();
        k_b = 0;
        while (k_b < 2 * BFR) begin
            e = exp_b(k_b);
            if (obs_b !== e) begin
                nbad++;
                if (first_k < 0) first_k = k_b;
            end
            if (k_b == 6 * BHT) en_b = 1'b0;
            if (k_b == 9 * BHT) en_b = 1'b1;
            if (k_b == 2 * BFR - 1) en_b = 1'b0;
            tick(); k_b++;
        end
        checks++;
        if (nbad !== 0) begin
            errors++; $display("FAIL cancel_stop: got %0d bad cycles expected 0 (first k=%0d)", nbad, first_k);
        end
        checks++;
        if (obs_b !== IDLE_VEC) begin
            errors++; $display("FAIL last_cycle_stop: got %h expected %h", obs_b, IDLE_VEC);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_mid_reset();
        int          nbad = 0;
        logic [40:0] e;
        en_b = 1'b1;
        tick();
        k_b = 0;
        while (k_b <= 7 * BHT + 8) begin
            e = exp_b(k_b);
            if (obs_b !== e) nbad++;
            if (k_b == 7 * BHT + 8) rst_b = 1'b1;
            tick(); k_b++;
        end
        checks++;
        if (obs_b !== IDLE_VEC || nbad !== 0) begin
            errors++; $display("FAIL mid_frame_reset: got %h (%0d bad before) expected %h", obs_b, nbad, IDLE_VEC);
        end
        rst_b = 1'b0; en_b = 1'b0;
        repeat (3) tick();
        checks++;
        if (obs_b !== IDLE_VEC) begin
            errors++; $display("FAIL idle_after_reset: got %h expected %h", obs_b, IDLE_VEC);
        end
        en_b = 1'b1;
        tick();
        e = exp_b(0);
        checks++;
        if (obs_b !== e) begin
            errors++; $display("FAIL restart_after_reset: got %h expected %h", obs_b, e);
        end
        en_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_request_align();
        test_vertical();
        test_stop();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
